misr_bist_compactor: RTL

- Parametrised multiple-input signature register (MISR) with an integrated compaction controller for the BIST response path.
- Compacts CHANNELS response bits per cycle into a WIDTH-bit signature over exactly NUM_PATTERNS valid cycles.
- Then freezes the signature and compares it against a golden value, producing pass/fail.
- Sits between the circuit-under-test outputs and the BIST controller; replaces fixed-width, fixed-seed signature registers.

---
 rtl/misr_pkg.sv | 29 ++
 rtl/misr_core.sv | 34 +++
 rtl/misr_bist_compactor.sv | 112 +++++++++++
 3 files changed

// File: rtl/misr_pkg.sv
// Shared types and the next-signature function for the MISR response compactor.
// misr_next works on a fixed maximum width so any signature width up to MISR_MAX_W can use it.
package misr_pkg;

  localparam int MISR_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } misr_state_e;

  // Galois step toward the MSB; msb selects the active width, bits above it are cleared.
  function automatic logic [MISR_MAX_W-1:0] misr_next(
    input logic [MISR_MAX_W-1:0] s,
    input logic [MISR_MAX_W-1:0] d,
    input logic [MISR_MAX_W-1:0] poly,
    input logic [5:0]            msb
  );
    logic                  fb;
    logic [MISR_MAX_W-1:0] taps;
    logic [MISR_MAX_W-1:0] mask;
    fb   = s[msb];
    taps = fb ? ((poly & ~MISR_MAX_W'(1)) | MISR_MAX_W'(1)) : '0;
    mask = {MISR_MAX_W{1'b1}} >> (6'd63 - msb);
    return ((s << 1) ^ taps ^ d) & mask;
  endfunction

endpackage

// File: rtl/misr_core.sv
// Signature register datapath: load SEED or take one compaction step per enabled cycle.
// Exposes the next-state value so the controller can compare the final signature on the closing edge.
module misr_core
  import misr_pkg::*;
#(
  parameter int               WIDTH    = 24,
  parameter int               CHANNELS = 3,
  parameter logic [WIDTH-1:0] POLY     = 24'h00001B,
  parameter logic [WIDTH-1:0] SEED     = 24'hB76DB9
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                load,
  input  logic                shift,
  input  logic [CHANNELS-1:0] din,
  output logic [WIDTH-1:0]    sig,
  output logic [WIDTH-1:0]    sig_next
);

  assign sig_next = WIDTH'(misr_next(MISR_MAX_W'(sig), MISR_MAX_W'(din),
                                     MISR_MAX_W'(POLY), 6'(WIDTH-1)));

  // load wins over shift so a restart never mixes in a stale response.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sig <= SEED;
    end else if (load) begin
      sig <= SEED;
    end else if (shift) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/misr_bist_compactor.sv
// BIST response compactor: runs the MISR over exactly NUM_PATTERNS valid cycles, then
// freezes the signature and reports whether it matches GOLDEN.
//
// Handshake: din is consumed on a rising edge only when din_valid=1 and busy=1 (no back-pressure);
// start is a one-cycle request honoured outside RUN; abort wins over start and din_valid.
module misr_bist_compactor
  import misr_pkg::*;
#(
  parameter int               WIDTH        = 24,
  parameter int               CHANNELS     = 3,
  parameter logic [WIDTH-1:0] POLY         = 24'h00001B,
  parameter logic [WIDTH-1:0] SEED         = 24'hB76DB9,
  parameter logic [WIDTH-1:0] GOLDEN       = 24'h000000,
  parameter int               NUM_PATTERNS = 1024,
  parameter int               CNT_W        = $clog2(NUM_PATTERNS + 1)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                start,
  input  logic                abort,
  input  logic                din_valid,
  input  logic [CHANNELS-1:0] din,
  output logic                busy,
  output logic [WIDTH-1:0]    sig,
  output logic                sig_valid,
  output logic                pass,
  output logic [CNT_W-1:0]    pattern_count,
  output logic [1:0]          state_dbg
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PATTERNS - 1);

  misr_state_e      state;
  logic             load;
  logic             shift;
  logic             last;
  logic             pass_q;
  logic [WIDTH-1:0] sig_next;

  assign load  = !abort && start && (state != RUN);
  assign shift = !abort && din_valid && (state == RUN);
  assign last  = shift && (pattern_count == LAST_CNT);

  misr_core #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS),
    .POLY     (POLY),
    .SEED     (SEED)
  ) u_core (
    .CLK      (CLK),
    .RST      (RST),
    .load     (load),
    .shift    (shift),
    .din      (din),
    .sig      (sig),
    .sig_next (sig_next)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= IDLE;
      pattern_count <= '0;
      pass_q        <= 1'b0;
      busy          <= 1'b0;
      sig_valid     <= 1'b0;
    end else if (abort) begin
      // Count and pass are kept so the aborted run can still be inspected.
      state     <= IDLE;
      busy      <= 1'b0;
      sig_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            state         <= RUN;
            pattern_count <= '0;
            busy          <= 1'b1;
          end
        end
        RUN: begin
          if (shift) begin
            pattern_count <= pattern_count + 1'b1;
          end
          if (last) begin
            // Compare the value being written so pass is valid in the first DONE cycle.
            state     <= DONE;
            busy      <= 1'b0;
            sig_valid <= 1'b1;
            pass_q    <= (sig_next == GOLDEN);
          end
        end
        DONE: begin
          if (load) begin
            state         <= RUN;
            pattern_count <= '0;
            busy          <= 1'b1;
            sig_valid     <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          sig_valid <= 1'b0;
        end
      endcase
    end
  end

  assign pass      = pass_q && (state == DONE);
  assign state_dbg = state;

endmodule
